// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the display-side generator and the sync decoder,
// plus the decoder's lock FSM encoding.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam logic [10:0] H_CNT_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } sync_state_t;

endpackage

// File: rtl/vga_edge_detect.sv
// One-flop input capture normalised to active-high, with rise/fall pulses taken
// against a second flop.
module vga_edge_detect #(
    parameter logic POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            level   <= (din == POL);
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from VGA sync/blank, measures line and frame timing,
// and locks after LOCK_FRAMES consecutive clean frames.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   H_TOTAL     = VGA_H_TOTAL,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   V_TOTAL     = VGA_V_TOTAL,
    parameter int   LOCK_FRAMES = 2,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0
) (
    input  logic        VGA_CLK,
    input  logic        RESET,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_N,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pixel_valid,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_error,
    output logic [10:0] h_meas,
    output logic [9:0]  v_meas,
    output logic [7:0]  err_count
);

    localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);
    localparam logic [9:0]  Y_ACT  = 10'(V_ACTIVE);
    localparam logic [3:0]  GOOD_N = 4'(LOCK_FRAMES);

    logic hs_q, vs_q, de_q;
    logic hs_start, vs_start, de_rise, de_fall;
    logic hs_fall, vs_fall;
    logic unused_edges;

    logic [10:0] h_cnt, h_meas_nxt;
    logic [9:0]  v_cnt, v_meas_nxt;
    logic        h_armed, de_armed;
    logic        line_err, sat_err, de_err, frame_err, mismatch;

    sync_state_t state, state_nxt;
    logic [3:0]  good_cnt, good_nxt;

    vga_edge_detect #(.POL(HS_POL)) u_hs (
        .clk(VGA_CLK), .rst(RESET), .din(VGA_HS), .level(hs_q), .rise(hs_start), .fall(hs_fall));
    vga_edge_detect #(.POL(VS_POL)) u_vs (
        .clk(VGA_CLK), .rst(RESET), .din(VGA_VS), .level(vs_q), .rise(vs_start), .fall(vs_fall));
    vga_edge_detect #(.POL(1'b1)) u_de (
        .clk(VGA_CLK), .rst(RESET), .din(VGA_BLANK_N), .level(de_q), .rise(de_rise), .fall(de_fall));

    assign unused_edges = hs_fall ^ vs_fall ^ hs_q ^ vs_q;

    // h_meas saturates with h_cnt so a lost sync reads back as 2047, not a wrapped 0
    assign h_meas_nxt = (h_cnt == H_CNT_MAX) ? H_CNT_MAX : h_cnt + 11'd1;
    assign v_meas_nxt = hs_start ? v_cnt + 10'd1 : v_cnt;

    // armed flags keep the partial line/run seen straight after reset out of the checks
    assign line_err  = hs_start & h_armed & (h_meas_nxt != H_TOT);
    assign sat_err   = (h_cnt == H_CNT_MAX);
    assign de_err    = de_armed & ((de_q & ~de_rise & (x == X_LAST)) |
                                   (de_fall & (x != X_LAST)));
    assign frame_err = vs_start & ((v_meas_nxt != V_TOT) | (y != Y_ACT));
    assign mismatch  = (state != ST_SEARCH) & (line_err | sat_err | de_err | frame_err);

    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_meas      <= '0;
            v_meas      <= '0;
            h_armed     <= 1'b0;
            de_armed    <= 1'b0;
            x           <= '0;
            y           <= '0;
            pixel_valid <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            err_count   <= '0;
        end else begin
            if (hs_start) begin
                h_cnt   <= '0;
                h_meas  <= h_meas_nxt;
                h_armed <= 1'b1;
            end else if (h_cnt != H_CNT_MAX) begin
                h_cnt <= h_cnt + 11'd1;
            end

            if (vs_start) begin
                v_cnt  <= '0;
                v_meas <= v_meas_nxt;
            end else if (hs_start) begin
                v_cnt <= v_cnt + 10'd1;
            end

            if (de_rise) begin
                x        <= '0;
                de_armed <= 1'b1;
            end else if (de_q) begin
                x <= x + 10'd1;
            end

            if (vs_start)     y <= '0;
            else if (de_fall) y <= y + 10'd1;

            pixel_valid <= de_q & locked;
            line_start  <= de_rise & locked;
            frame_start <= de_rise & locked & (y == 10'd0);

            if (timing_error && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        case (state)
            ST_SEARCH: begin
                if (vs_start) begin
                    state_nxt = ST_MEASURE;
                    good_nxt  = '0;
                end
            end
            ST_MEASURE: begin
                if (mismatch) begin
                    state_nxt = ST_SEARCH;
                end else if (vs_start) begin
                    good_nxt = good_cnt + 4'd1;
                    if (good_nxt == GOOD_N) state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (mismatch) state_nxt = ST_SEARCH;
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    always_comb begin
        locked       = (state == ST_LOCKED);
        timing_error = (state == ST_LOCKED) & mismatch;
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster (20x8 active, 32x12 total)
// with sync leading each line/frame so HS and VS start together at every frame.
module tb_vga_sync_decoder;

    localparam int HA = 20;
    localparam int HT = 32;
    localparam int VA = 8;
    localparam int VT = 12;

    logic        VGA_CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        VGA_HS = 1'b1;
    logic        VGA_VS = 1'b1;
    logic        VGA_BLANK_N = 1'b0;
    logic [9:0]  x, y;
    logic        pixel_valid, line_start, frame_start, locked, timing_error;
    logic [10:0] h_meas;
    logic [9:0]  v_meas;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int te_cnt = 0, ls_cnt = 0, fs_cnt = 0, fs_bad = 0, te_lock_bad = 0;
    bit te_prev = 1'b0;
    bit last_px_seen = 1'b0;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .LOCK_FRAMES(2), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .VGA_CLK(VGA_CLK), .RESET(RESET), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .x(x), .y(y), .pixel_valid(pixel_valid),
        .line_start(line_start), .frame_start(frame_start), .locked(locked),
        .timing_error(timing_error), .h_meas(h_meas), .v_meas(v_meas), .err_count(err_count)
    );

    always #20 VGA_CLK = ~VGA_CLK;

    // event recorder; the tests compare what it saw
    always @(negedge VGA_CLK) begin
        if (timing_error === 1'b1) te_cnt++;
        if (line_start === 1'b1) ls_cnt++;
        if (frame_start === 1'b1) begin
            fs_cnt++;
            if (x !== 10'd0 || y !== 10'd0 || pixel_valid !== 1'b1) fs_bad++;
        end
        if (pixel_valid === 1'b1 && x === 10'(HA - 1) && y === 10'(VA - 1)) last_px_seen = 1'b1;
        if ((te_prev && locked === 1'b1) || (timing_error === 1'b1 && locked !== 1'b1)) te_lock_bad++;
        te_prev = (timing_error === 1'b1);
    end

    task automatic tick();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic px(input int l, input int p, input int de_len);
        VGA_HS      = (p < 4) ? 1'b0 : 1'b1;
        VGA_VS      = (l < 2) ? 1'b0 : 1'b1;
        VGA_BLANK_N = (l >= 2 && l < 2 + VA && p >= 8 && p < 8 + de_len);
        tick();
    endtask

    task automatic run_line(input int l, input int len, input int de_len);
        for (int p = 0; p < len; p++) px(l, p, de_len);
    endtask

    task automatic run_lines(input int from, input int upto);
        for (int l = from; l < upto; l++) run_line(l, HT, HA);
    endtask

    task automatic run_frame();
        run_lines(0, VT);
    endtask

    task automatic frame_head();
        for (int p = 0; p < 3; p++) px(0, p, HA);
    endtask

    task automatic frame_tail();
        for (int p = 3; p < HT; p++) px(0, p, HA);
        run_lines(1, VT);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({x, y, pixel_valid, line_start, frame_start, locked, timing_error, h_meas, v_meas, err_count} !== 54'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: x=%0d y=%0d pv=%b ls=%b fs=%b lk=%b te=%b hm=%0d vm=%0d ec=%0d, want all 0",
                     x, y, pixel_valid, line_start, frame_start, locked, timing_error, h_meas, v_meas, err_count);
        end
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        RESET = 1'b0;
    endtask

    task automatic test_nominal();
        int ls0, fs0;
        run_frame();
        run_frame();
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL nominal_prelock: got %b want 0", locked); end
        ls0 = ls_cnt;
        fs0 = fs_cnt;
        run_frame();
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL nominal_locked: got %b want 1", locked); end
        n_cmp++;
        if (h_meas !== 11'd32) begin n_bad++; $display("FAIL nominal_h_meas: got %0d want 32", h_meas); end
        n_cmp++;
        if (v_meas !== 10'd12) begin n_bad++; $display("FAIL nominal_v_meas: got %0d want 12", v_meas); end
        n_cmp++;
        if (last_px_seen !== 1'b1) begin n_bad++; $display("FAIL nominal_last_pixel: got %b want 1", last_px_seen); end
        n_cmp++;
        if (ls_cnt - ls0 !== 8) begin n_bad++; $display("FAIL nominal_line_starts: got %0d want 8", ls_cnt - ls0); end
        n_cmp++;
        if (fs_cnt - fs0 !== 1) begin n_bad++; $display("FAIL nominal_frame_starts: got %0d want 1", fs_cnt - fs0); end
        n_cmp++;
        if (te_cnt !== 0) begin n_bad++; $display("FAIL nominal_no_error: got %0d want 0", te_cnt); end
    endtask

    task automatic test_long_line();
        int te0;
        te0 = te_cnt;
        run_lines(0, 4);
        run_line(4, HT + 1, HA);
        for (int p = 0; p < 3; p++) px(5, p, HA);
        n_cmp++;
        if (h_meas !== 11'd33) begin n_bad++; $display("FAIL long_h_meas: got %0d want 33", h_meas); end
        n_cmp++;
        if (te_cnt - te0 !== 1) begin n_bad++; $display("FAIL long_te_pulses: got %0d want 1", te_cnt - te0); end
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL long_unlocked: got %b want 0", locked); end
        n_cmp++;
        if (err_count !== 8'd1) begin n_bad++; $display("FAIL long_err_count: got %0d want 1", err_count); end
        for (int p = 3; p < HT; p++) px(5, p, HA);
        run_lines(6, VT);
        n_cmp++;
        if (te_lock_bad !== 0) begin n_bad++; $display("FAIL long_te_lock_timing: got %0d want 0", te_lock_bad); end
    endtask

    task automatic test_wide_active();
        int te0;
        te0 = te_cnt;
        run_lines(0, 3);
        run_line(3, HT, HA + 1);
        run_lines(4, VT);
        run_frame();
        frame_head();
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL wide_not_locked_yet: got %b want 0", locked); end
        frame_tail();
        frame_head();
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL wide_relocked: got %b want 1", locked); end
        frame_tail();
        n_cmp++;
        if (te_cnt !== te0) begin n_bad++; $display("FAIL wide_no_te: got %0d want %0d", te_cnt, te0); end
        n_cmp++;
        if (err_count !== 8'd1) begin n_bad++; $display("FAIL wide_err_count: got %0d want 1", err_count); end
    endtask

    task automatic test_hs_loss();
        int te0;
        te0 = te_cnt;
        run_lines(0, 4);
        VGA_HS = 1'b1;
        VGA_VS = 1'b1;
        VGA_BLANK_N = 1'b0;
        repeat (2100) tick();
        n_cmp++;
        if (te_cnt - te0 !== 1) begin n_bad++; $display("FAIL hsloss_te_pulses: got %0d want 1", te_cnt - te0); end
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL hsloss_unlocked: got %b want 0", locked); end
        n_cmp++;
        if (err_count !== 8'd2) begin n_bad++; $display("FAIL hsloss_err_count: got %0d want 2", err_count); end
        frame_head();
        n_cmp++;
        if (h_meas !== 11'd2047) begin n_bad++; $display("FAIL hsloss_h_meas: got %0d want 2047", h_meas); end
        n_cmp++;
        if (v_meas !== 10'd4) begin n_bad++; $display("FAIL hsloss_v_meas: got %0d want 4", v_meas); end
    endtask

    task automatic test_reset_midstream();
        for (int p = 3; p < HT; p++) px(0, p, HA);
        run_lines(1, 5);
        for (int p = 0; p < 10; p++) px(5, p, HA);
        RESET = 1'b1;
        for (int p = 10; p < 13; p++) px(5, p, HA);
        n_cmp++;
        if ({x, y, pixel_valid, line_start, frame_start, locked, timing_error, h_meas, v_meas, err_count} !== 54'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: x=%0d y=%0d pv=%b lk=%b te=%b hm=%0d vm=%0d ec=%0d, want all 0",
                     x, y, pixel_valid, locked, timing_error, h_meas, v_meas, err_count);
        end
        RESET = 1'b0;
        for (int p = 13; p < HT; p++) px(5, p, HA);
        run_lines(6, VT);
        run_frame();
        run_frame();
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL midreset_prelock: got %b want 0", locked); end
    endtask

    task automatic test_coincident();
        int fs0, te0;
        fs0 = fs_cnt;
        te0 = te_cnt;
        frame_head();
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL coinc_locked: got %b want 1", locked); end
        n_cmp++;
        if (y !== 10'd0) begin n_bad++; $display("FAIL coinc_y_zero: got %0d want 0", y); end
        n_cmp++;
        if (v_meas !== 10'd12) begin n_bad++; $display("FAIL coinc_v_meas: got %0d want 12", v_meas); end
        frame_tail();
        n_cmp++;
        if (fs_cnt - fs0 !== 1) begin n_bad++; $display("FAIL coinc_frame_start: got %0d want 1", fs_cnt - fs0); end
        n_cmp++;
        if (fs_bad !== 0) begin n_bad++; $display("FAIL coinc_fs_at_origin: got %0d bad want 0", fs_bad); end
        n_cmp++;
        if (err_count !== 8'd0 || te_cnt !== te0) begin
            n_bad++;
            $display("FAIL coinc_clean: err_count=%0d te=%0d want 0 and %0d", err_count, te_cnt, te0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_long_line();
        test_wide_active();
        test_hs_loss();
        test_reset_midstream();
        test_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
